// File: rtl/lif_param_loader.sv
// Bit-serial loader for the lif_neuron parameter set: hunts for a sync header, shifts a 24-bit
// payload into a shadow register and commits it atomically. Define LOAD_CHECKSUM_EN for a trailing nibble check.
module lif_param_loader #(
  parameter logic [7:0] SYNC_WORD      = 8'hA5,
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255,
  parameter logic [2:0] DEF_WEIGHT     = 3'd1,
  parameter logic [7:0] DEF_THR_MIN    = 8'd16,
  parameter logic [7:0] DEF_THR_MAX    = 8'd64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ser_valid,
  input  logic       ser_data,
  input  logic       clear_ready,
  output logic [2:0] weight_a,
  output logic [2:0] weight_b,
  output logic [1:0] leak_config,
  output logic [7:0] threshold_min,
  output logic [7:0] threshold_max,
  output logic       params_ready,
  output logic       busy,
  output logic       load_done,
  output logic       load_err
);
  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

  state_t      state;
  logic [6:0]  hdr;        // last 7 header bits; the 8th comes straight from ser_data
  logic [7:0]  hdr_nxt;
  logic [4:0]  bit_cnt;
  logic [7:0]  idle_cnt;
  logic [23:0] frame;
  logic        thr_ok, frame_end, frame_ok, abort;

`ifdef LOAD_CHECKSUM_EN
  logic [23:0] shadow, shadow_shift;
  logic [2:0]  chk_sr;
  logic [3:0]  nib_x;
  assign frame        = shadow;
  assign shadow_shift = {shadow[22:0], ser_data};
  assign nib_x        = frame[23:20] ^ frame[19:16] ^ frame[15:12] ^
                        frame[11:8] ^ frame[7:4] ^ frame[3:0];
  assign frame_end    = ser_valid && (state == CHECK) && (bit_cnt == 5'd3);
  assign frame_ok     = thr_ok && ({chk_sr, ser_data} == nib_x);
`else
  // Without the checksum the last payload bit is judged on the edge it arrives.
  logic [22:0] shadow, shadow_shift;
  assign frame        = {shadow, ser_data};
  assign shadow_shift = frame[22:0];
  assign frame_end    = ser_valid && (state == PAYLOAD) && (bit_cnt == 5'd23);
  assign frame_ok     = thr_ok;
`endif

  assign hdr_nxt = {hdr, ser_data};
  assign thr_ok  = frame[15:8] <= frame[7:0];
  assign abort   = (state != HUNT) && !ser_valid && (idle_cnt == TIMEOUT_CYCLES - 8'd1);
  assign busy    = (state != HUNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= HUNT;
      hdr           <= '0;
      shadow        <= '0;
      bit_cnt       <= '0;
      idle_cnt      <= '0;
`ifdef LOAD_CHECKSUM_EN
      chk_sr        <= '0;
`endif
      weight_a      <= DEF_WEIGHT;
      weight_b      <= DEF_WEIGHT;
      leak_config   <= 2'b00;
      threshold_min <= DEF_THR_MIN;
      threshold_max <= DEF_THR_MAX;
      params_ready  <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
    end else begin
      load_done <= 1'b0;
      load_err  <= 1'b0;
      if (clear_ready) params_ready <= 1'b0;

      case (state)
        HUNT: if (ser_valid) begin
          hdr <= hdr_nxt[6:0];
          if (hdr_nxt == SYNC_WORD) begin
            state    <= PAYLOAD;
            bit_cnt  <= '0;
            idle_cnt <= '0;
          end
        end
        PAYLOAD: if (ser_valid) begin
          shadow  <= shadow_shift;
          bit_cnt <= bit_cnt + 5'd1;
`ifdef LOAD_CHECKSUM_EN
          if (bit_cnt == 5'd23) begin
            state   <= CHECK;
            bit_cnt <= '0;
          end
`endif
        end
`ifdef LOAD_CHECKSUM_EN
        CHECK: if (ser_valid) begin
          chk_sr  <= {chk_sr[1:0], ser_data};
          bit_cnt <= bit_cnt + 5'd1;
        end
`endif
        default: state <= HUNT;
      endcase

      if (state != HUNT) idle_cnt <= ser_valid ? 8'd0 : idle_cnt + 8'd1;

      // Header cleared on exit so stale payload/header bits can never alias a new sync word.
      if (frame_end || abort) begin
        state <= HUNT;
        hdr   <= '0;
      end
      if (frame_end && frame_ok) begin
        weight_a      <= frame[23:21];
        weight_b      <= frame[20:18];
        leak_config   <= frame[17:16];
        threshold_min <= frame[15:8];
        threshold_max <= frame[7:0];
        params_ready  <= 1'b1;
        load_done     <= 1'b1;
      end
      if ((frame_end && !frame_ok) || abort) load_err <= 1'b1;
    end
  end
endmodule
